audio_out_pwm: RTL and testbench
================================

Name: audio_out_pwm

Overview:
- Final output stage; sits directly downstream of the inverse FFT instance (fft_1).
- Accepts time-domain frames from the IFFT over an AXI-Stream-style handshake and buffers them in a FIFO.
- Releases one sample per audio sample period, converts it to a PWM duty cycle, and drives the board audio amplifier pins aud_pwm and aud_sd.

Parameters:
- DATA_WIDTH, 16, signed real-sample width; s_data is 2*DATA_WIDTH wide, with real in the low half and imaginary in the high half (imaginary ignored).
- PWM_BITS, 8, PWM resolution; PWM period is 2^PWM_BITS clocks; requires 2^PWM_BITS <= CLK_DIV.
- CLK_DIV, 2268, clocks per audio sample (100 MHz / 2268 ≈ 44.09 kHz).
- FIFO_DEPTH, 1024, sample FIFO depth; must be a power of 2.
- PREFILL, 512, FIFO occupancy required before playback starts; 1 <= PREFILL <= FIFO_DEPTH.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- s_data  in  2*DATA_WIDTH  IFFT m_axis_data_tdata.
- s_valid  in  1  IFFT tvalid.
- s_last  in  1  IFFT tlast (frame end).
- s_ready  out  1  to IFFT tready.
- aud_pwm  out  1  PWM audio output.
- aud_sd  out  1  amplifier enable (1 = on).
- underrun  out  1  one-cycle pulse on FIFO underrun.
- frames_rx  out  16  count of accepted s_last beats, wraps.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low on reset_n.
- Reset values: aud_pwm=0, aud_sd=0, underrun=0, frames_rx=0, s_ready=0. FIFO is empty, state=FILL, all counters 0.
  - Applies at any time, including mid-frame or mid-playback. Partially received frames are discarded; the upstream IFFT is re-reset by the same reset_n.
- aud_sd is registered and goes to 1 on the first clock after reset release.
- Input handshake:
  - A beat transfers when s_valid && s_ready.
  - s_ready = (count != FIFO_DEPTH), derived from the registered count; an in-progress pop is not credited.
  - A transfer writes s_data[DATA_WIDTH-1:0] to the FIFO.
  - A transfer with s_last=1 increments frames_rx.
- Occupancy: simultaneous push and pop leave count unchanged. A push with count==FIFO_DEPTH is impossible because s_ready=0.
- Sample tick:
  - tick_cnt is free-running, 0..CLK_DIV-1, starting after reset.
  - tick is asserted for one cycle when tick_cnt==CLK_DIV-1.
- FSM:
  - FILL: no pops. On tick, duty_next is set to mid-scale (2^(PWM_BITS-1)). Moves to PLAY when count >= PREFILL, evaluated every cycle.
  - PLAY, tick with count>0: pop one sample; on the next cycle duty_next = conv(sample).
  - PLAY, tick with count==0: underrun=1 for that cycle, duty_next = mid-scale, next state FILL.
- Conversion: conv(s) = {~s[DATA_WIDTH-1], s[DATA_WIDTH-2 : DATA_WIDTH-PWM_BITS]}, i.e. offset-binary truncation.
  - Examples (16b→8b): -32768→0, -1→127, 0→128, 32767→255.
- PWM:
  - pwm_cnt is free-running, 0..2^PWM_BITS-1.
  - duty_active loads from duty_next only on the cycle pwm_cnt wraps to 0, so there are no mid-period glitches.
  - aud_pwm is registered: aud_pwm = (pwm_cnt < duty_active).
  - duty 0 gives a constant 0; duty 2^PWM_BITS-1 gives high for all but 1 clock per period.
- Latency: a tick pop reaches duty_next 1 clock later. It reaches duty_active at the next pwm_cnt wrap, at most 2^PWM_BITS+1 clocks after the tick.
- The FIFO read is synchronous (1-cycle read latency); the pop on the tick cycle provides the data used for duty_next the cycle after.

Decomposition:
- Shared package holds:
  - audio constants: DATA_WIDTH=16, PWM_BITS=8, CLK_DIV=2268;
  - FFT frame length;
  - state encoding localparams ST_FILL, ST_PLAY.
- One sub-module: sample_fifo.
  - Parameterised synchronous FIFO (width, power-of-2 depth) with block-RAM inference.
  - Registered count output, 1-cycle read latency.
  - The PWM, tick and FSM logic stay in audio_out_pwm.

Test Plan (bench parameters: CLK_DIV=300, PWM_BITS=8, FIFO_DEPTH=16, PREFILL=8):
- Reset: hold reset_n=0 while driving s_valid=1 → s_ready=0, aud_pwm=0, aud_sd=0, frames_rx=0. Assert reset_n=0 mid-PLAY → outputs return to reset values immediately, without waiting for a clock edge.
- Prefill: push 7 samples → state stays FILL and aud_pwm shows a 128/256 duty. Push the 8th → PLAY; the first pop happens on the next tick.
- Conversion: push 0x8000, 0xFFFF, 0x0000, 0x7FFF (+4 fillers) → measured high-times per PWM period are 0, 127, 128, 255 clocks on successive samples.
- Backpressure: push continuously with no ticks consumed (first 16 beats before PLAY pops) → s_ready=0 at count=16. After a pop, s_ready returns to 1 the following cycle. No data is lost or duplicated (scoreboard).
- Underrun: after PLAY, stop input → exactly one underrun pulse on the first tick with count==0; duty returns to 128; state=FILL. Refill 8 samples → playback resumes.
- Frames: send 3 frames of 4 beats with s_last on every 4th beat → frames_rx=3. Imaginary halves set to random values do not affect the duty.

Source files
------------

// File: rtl/audio_out_pwm_pkg.sv
// Shared constants and state encoding for the audio PWM output stage.
package audio_out_pwm_pkg;

   localparam int AUD_DATA_WIDTH = 16;
   localparam int AUD_PWM_BITS   = 8;
   localparam int AUD_CLK_DIV    = 2268;
   localparam int FFT_FRAME_LEN  = 1024;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_PLAY = 1'b1
   } state_t;

endpackage

// File: rtl/audio_out_pwm_sample_fifo.sv
// Synchronous power-of-2 FIFO with registered occupancy and a registered read
// port, so the storage maps onto block RAM.
module sample_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 1024
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_ok, rd_ok;

   always_comb begin
      wr_ok    = wr_en && (count_q != FULL);
      rd_ok    = rd_en && (count_q != '0);
      wr_ptr_d = wr_ptr_q + AW'(wr_ok);
      rd_ptr_d = rd_ptr_q + AW'(rd_ok);
      count_d  = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is left unreset so it can be inferred as RAM.
   always_ff @(posedge clock) begin
      if (wr_ok) mem[wr_ptr_q] <= wr_data;
      if (rd_ok) rd_data_q <= mem[rd_ptr_q];
   end

   assign rd_data = rd_data_q;
   assign count   = count_q;

endmodule

// File: rtl/audio_out_pwm.sv
// Buffers IFFT samples, releases one per audio period and drives a PWM
// audio amplifier with the offset-binary truncated sample as duty cycle.
module audio_out_pwm
   import audio_out_pwm_pkg::*;
#(
   parameter int DATA_WIDTH = AUD_DATA_WIDTH,
   parameter int PWM_BITS   = AUD_PWM_BITS,
   parameter int CLK_DIV    = AUD_CLK_DIV,
   parameter int FIFO_DEPTH = 1024,
   parameter int PREFILL    = 512
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [2*DATA_WIDTH-1:0] s_data,
   input  logic                    s_valid,
   input  logic                    s_last,
   output logic                    s_ready,
   output logic                    aud_pwm,
   output logic                    aud_sd,
   output logic                    underrun,
   output logic [15:0]             frames_rx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(CLK_DIV);
   localparam logic [CW-1:0]       FULL_C    = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0]       PREFILL_C = CW'(PREFILL);
   localparam logic [TW-1:0]       TICK_LAST = TW'(CLK_DIV - 1);
   localparam logic [PWM_BITS-1:0] MID       = {1'b1, {(PWM_BITS-1){1'b0}}};

   function automatic logic [PWM_BITS-1:0] conv(input logic signed [DATA_WIDTH-1:0] s);
      return {~s[DATA_WIDTH-1], s[DATA_WIDTH-2 -: PWM_BITS-1]};
   endfunction

   logic [CW-1:0]         fifo_count;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  push, pop, tick;
   logic                  unused_bits;

   state_t                state_q, state_d;
   logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
   logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
   logic [PWM_BITS-1:0]   duty_next_q, duty_next_d;
   logic [PWM_BITS-1:0]   duty_active_q, duty_active_d;
   logic                  pop_dly_q;
   logic                  aud_pwm_q, aud_pwm_d;
   logic                  aud_sd_q;
   logic [15:0]           frames_rx_q, frames_rx_d;

   // The amplifier-enable flop doubles as "out of reset" so s_ready is low in reset.
   assign s_ready  = aud_sd_q && (fifo_count != FULL_C);
   assign push     = s_valid && s_ready;
   assign tick     = (tick_cnt_q == TICK_LAST);
   assign pop      = (state_q == ST_PLAY) && tick && (fifo_count != '0);
   assign underrun = (state_q == ST_PLAY) && tick && (fifo_count == '0);

   sample_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_en   (push),
      .wr_data (s_data[DATA_WIDTH-1:0]),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .count   (fifo_count)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FILL: if (fifo_count >= PREFILL_C) state_d = ST_PLAY;
         ST_PLAY: if (underrun) state_d = ST_FILL;
         default: state_d = ST_FILL;
      endcase
   end

   always_comb begin
      tick_cnt_d    = tick ? '0 : tick_cnt_q + TW'(1);
      pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
      aud_pwm_d     = (pwm_cnt_q < duty_active_q);
      frames_rx_d   = frames_rx_q + 16'(push && s_last);
      // Duty only changes at a period boundary to avoid truncated pulses.
      duty_active_d = (pwm_cnt_q == '1) ? duty_next_q : duty_active_q;
      duty_next_d   = duty_next_q;
      if (pop_dly_q)
         duty_next_d = conv(fifo_rd_data);
      else if (tick && ((state_q == ST_FILL) || underrun))
         duty_next_d = MID;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= ST_FILL;
      else          state_q <= state_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt_q    <= '0;
         pwm_cnt_q     <= '0;
         duty_next_q   <= MID;
         duty_active_q <= '0;
         pop_dly_q     <= 1'b0;
         aud_pwm_q     <= 1'b0;
         aud_sd_q      <= 1'b0;
         frames_rx_q   <= '0;
      end else begin
         tick_cnt_q    <= tick_cnt_d;
         pwm_cnt_q     <= pwm_cnt_d;
         duty_next_q   <= duty_next_d;
         duty_active_q <= duty_active_d;
         pop_dly_q     <= pop;
         aud_pwm_q     <= aud_pwm_d;
         aud_sd_q      <= 1'b1;
         frames_rx_q   <= frames_rx_d;
      end
   end

   assign aud_pwm     = aud_pwm_q;
   assign aud_sd      = aud_sd_q;
   assign frames_rx   = frames_rx_q;
   assign unused_bits = ^{s_data[2*DATA_WIDTH-1:DATA_WIDTH], fifo_rd_data};

endmodule

// File: tb/tb_audio_out_pwm.sv
// Randomized bench for audio_out_pwm, checked every cycle against a
// sample-level behavioural model plus a few hand-derived duty expectations.
module tb_audio_out_pwm;

   localparam int DW  = 16;
   localparam int PB  = 8;
   localparam int CD  = 300;
   localparam int FD  = 16;
   localparam int PF  = 8;
   localparam int PER = 256;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_last = 1'b0;
   logic        s_ready, aud_pwm, aud_sd, underrun;
   logic [15:0] frames_rx;

   always #5 clock = ~clock;

   audio_out_pwm #(
      .DATA_WIDTH (DW),
      .PWM_BITS   (PB),
      .CLK_DIV    (CD),
      .FIFO_DEPTH (FD),
      .PREFILL    (PF)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .aud_pwm   (aud_pwm),
      .aud_sd    (aud_sd),
      .underrun  (underrun),
      .frames_rx (frames_rx)
   );

   int checks = 0;
   int errors = 0;
   int prints = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (prints < 40) begin
            $display("FAIL %s: got %0d, want %0d at t=%0t", name, act, exp, $time);
            prints++;
         end
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at t=%0t", name, $time);
   endtask

   // Behavioural model: sample queue, playback flag, duty values, cycle index.
   int     mq[$];
   bit     m_play, m_pend, m_pwm, m_sd;
   int     m_dnext, m_dactive, m_pval, m_frames, m_acc;
   longint m_k;

   function automatic int conv(input int s);
      return (s + 32768) / 256;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_play = 0; m_pend = 0; m_pwm = 0; m_sd = 0;
      m_dnext = 128; m_dactive = 0; m_pval = 0;
      m_frames = 0; m_acc = 0; m_k = 0;
   endtask

   task automatic model_step();
      bit tick;
      int pc, sz;
      bit ready;
      tick  = (m_k % CD) == CD - 1;
      pc    = int'(m_k % PER);
      sz    = mq.size();
      ready = m_sd && (sz != FD);
      m_pwm = pc < m_dactive;
      if (pc == PER - 1) m_dactive = m_dnext;
      if (m_pend) m_dnext = conv(m_pval);
      else if (tick && (!m_play || sz == 0)) m_dnext = 128;
      m_pend = 0;
      if (m_play && tick && sz > 0) begin
         m_pval = mq.pop_front();
         m_pend = 1;
      end
      if (s_valid && ready) begin
         mq.push_back(int'($signed(s_data[15:0])));
         if (s_last) m_frames = (m_frames + 1) % 65536;
         m_acc++;
      end
      if (!m_play && sz >= PF) m_play = 1;
      else if (m_play && tick && sz == 0) m_play = 0;
      m_sd = 1;
      m_k++;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clock or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step();
      end
   end

   // Cycle-by-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clock);
         check("aud_pwm", aud_pwm, m_pwm);
         check("aud_sd", aud_sd, m_sd);
         check("s_ready", s_ready, m_sd && (mq.size() != FD));
         check("underrun", underrun, m_play && ((m_k % CD) == CD - 1) && (mq.size() == 0));
         check("frames_rx", frames_rx, m_frames);
      end
   end

   // High-time per PWM period and underrun pulse count, measured from the pins.
   int hist[$];
   int win_acc = 0;
   int ur_cnt = 0;
   initial begin
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            win_acc = 0;
            hist.delete();
         end else begin
            if (underrun === 1'b1) ur_cnt++;
            win_acc += int'(aud_pwm === 1'b1);
            if (m_k % PER == 0) begin
               hist.push_back(win_acc);
               win_acc = 0;
            end
         end
      end
   end

   function automatic int last_win();
      if (hist.size() == 0) return -1;
      return hist[$];
   endfunction

   function automatic bit has_conv_seq();
      int d[$];
      foreach (hist[i]) if (d.size() == 0 || d[$] != hist[i]) d.push_back(hist[i]);
      for (int i = 0; i + 3 < d.size(); i++)
         if (d[i] == 0 && d[i+1] == 127 && d[i+2] == 128 && d[i+3] == 255) return 1;
      return 0;
   endfunction

   // Called at a falling edge; returns at the falling edge after the transfer.
   task automatic push_beat(input logic [15:0] re, input logic last);
      bit r;
      int n = 0;
      s_data  = {16'($urandom), re};
      s_valid = 1'b1;
      s_last  = last;
      forever begin
         r = s_ready;
         @(negedge clock);
         if (r) break;
         n++;
         if (n > 3000) begin
            timeout_fail("push_beat");
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   task automatic reset_pulse(input bit check_async);
      s_valid = 1'b0;
      s_last  = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      if (check_async) begin
         check("async rst s_ready", s_ready, 0);
         check("async rst aud_pwm", aud_pwm, 0);
         check("async rst aud_sd", aud_sd, 0);
         check("async rst frames_rx", frames_rx, 0);
         check("async rst underrun", underrun, 0);
      end
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int ur0, n;

      // Reset held with upstream valid asserted
      s_valid = 1'b1;
      s_data  = 32'h1234_5678;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check("rst s_ready", s_ready, 0);
      check("rst aud_pwm", aud_pwm, 0);
      check("rst aud_sd", aud_sd, 0);
      check("rst frames_rx", frames_rx, 0);
      check("rst underrun", underrun, 0);
      s_valid = 1'b0;
      reset_n = 1'b1;
      @(negedge clock);
      check("sd after release", aud_sd, 1);

      // Prefill: seven samples keep the output at mid-scale
      for (int i = 0; i < 7; i++) push_beat(16'($urandom), (i % 4) == 3);
      idle(800);
      check("prefill duty", last_win(), 128);
      check("prefill no underrun", ur_cnt, 0);
      push_beat(16'($urandom), 1'b1);
      idle(1);

      // Underrun once the FIFO drains
      ur0 = ur_cnt;
      n = 0;
      while (ur_cnt == ur0 && n < 6000) begin
         @(negedge clock);
         n++;
      end
      if (n >= 6000) timeout_fail("wait underrun");
      check("underrun seen", ur_cnt - ur0, 1);
      idle(600);
      check("underrun single pulse", ur_cnt - ur0, 1);
      check("underrun duty mid", last_win(), 128);

      // Refill resumes playback
      for (int i = 0; i < 8; i++) push_beat(16'h7FFF, (i % 4) == 3);
      idle(900);
      check("refill duty", last_win(), 255);

      // Asynchronous reset while playing
      reset_pulse(1'b1);

      // Conversion: -32768, -1, 0, 32767 then fillers
      push_beat(16'h8000, 1'b0);
      push_beat(16'hFFFF, 1'b0);
      push_beat(16'h0000, 1'b0);
      push_beat(16'h7FFF, 1'b0);
      for (int i = 0; i < 4; i++) push_beat(16'h0100, 1'b0);
      idle(1700);
      check("conv 0/127/128/255 sequence", has_conv_seq(), 1);
      reset_pulse(1'b0);

      // Backpressure: fill to capacity before the first pop
      for (int i = 0; i < 16; i++) push_beat(16'($urandom), 1'b0);
      idle(0);
      check("full s_ready", s_ready, 0);
      n = 0;
      while (!(m_k > 0 && (m_k % CD) == 0) && n < 1000) begin
         @(negedge clock);
         n++;
      end
      if (n >= 1000) timeout_fail("wait first pop");
      check("ready after pop", s_ready, 1);
      for (int i = 0; i < 4; i++) push_beat(16'($urandom), 1'b0);
      idle(50);
      check("accepted beats", m_acc, 20);
      reset_pulse(1'b0);

      // Frames: three frames of four beats, random imaginary halves
      for (int f = 0; f < 3; f++) begin
         for (int b = 0; b < 4; b++) begin
            push_beat(16'($urandom), b == 3);
            idle($urandom_range(0, 3));
         end
      end
      idle(2);
      check("frames_rx", frames_rx, 3);
      idle(1500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
